// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU load/store
// path and a byte-wide handshaked memory; misses are serviced one byte at a time.
module dcache_ctrl #(
   parameter int LINES = 8,
   parameter int BLOCK = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_read,
   input  logic       cpu_write,
   input  logic [7:0] cpu_address,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic       cpu_busy_wait,
   output logic       mem_read,
   output logic       mem_write,
   output logic [7:0] mem_address,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   input  logic       mem_busy_wait
);
   localparam int IDX_W = $clog2(LINES);
   localparam int OFF_W = $clog2(BLOCK);
   localparam int TAG_W = 8 - IDX_W - OFF_W;
   localparam logic [OFF_W-1:0] LAST_K = OFF_W'(BLOCK - 1);

   typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, FE_REQ, FE_WAIT, UPDATE} state_t;

   state_t           state_q;
   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [7:0]       data_q [LINES][BLOCK];
   logic [OFF_W-1:0] k_q;
   logic             mem_read_q;
   logic             mem_write_q;
   logic [7:0]       mem_address_q;
   logic [7:0]       mem_wdata_q;

   logic [TAG_W-1:0] cpu_tag;
   logic [IDX_W-1:0] idx;
   logic [OFF_W-1:0] off;
   logic             req;
   logic             hit;
   logic             read_hit;
   logic             write_hit;
   logic             miss;

   assign {cpu_tag, idx, off} = cpu_address;

   // Both request lines high together is a no-op, so it can never hit or miss.
   assign req       = cpu_read ^ cpu_write;
   assign hit       = req && valid_q[idx] && (tag_q[idx] == cpu_tag);
   assign read_hit  = hit && cpu_read && (state_q == IDLE);
   assign write_hit = hit && cpu_write && (state_q == IDLE);
   assign miss      = req && !hit && (state_q == IDLE);

   assign cpu_busy_wait = (state_q != IDLE) || miss;
   assign cpu_rdata     = read_hit ? data_q[idx][off] : 8'h00;
   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign mem_address   = mem_address_q;
   assign mem_wdata     = mem_wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         k_q           <= '0;
         valid_q       <= '0;
         dirty_q       <= '0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_address_q <= 8'h00;
         mem_wdata_q   <= 8'h00;
      end else begin
         case (state_q)
            IDLE: begin
               k_q <= '0;
               if (write_hit) begin
                  data_q[idx][off] <= cpu_wdata;
                  dirty_q[idx]     <= 1'b1;
               end else if (miss) begin
                  // The first byte request is raised on the way out of IDLE.
                  if (valid_q[idx] && dirty_q[idx]) begin
                     state_q       <= WB_REQ;
                     mem_write_q   <= 1'b1;
                     mem_address_q <= {tag_q[idx], idx, {OFF_W{1'b0}}};
                     mem_wdata_q   <= data_q[idx][0];
                  end else begin
                     state_q       <= FE_REQ;
                     mem_read_q    <= 1'b1;
                     mem_address_q <= {cpu_tag, idx, {OFF_W{1'b0}}};
                     valid_q[idx]  <= 1'b0;
                  end
               end
            end
            WB_REQ: begin
               mem_write_q   <= 1'b1;
               mem_address_q <= {tag_q[idx], idx, k_q};
               mem_wdata_q   <= data_q[idx][k_q];
               if (mem_busy_wait) state_q <= WB_WAIT;
            end
            WB_WAIT: begin
               if (!mem_busy_wait) begin
                  mem_write_q <= 1'b0;
                  if (k_q == LAST_K) begin
                     k_q          <= '0;
                     state_q      <= FE_REQ;
                     valid_q[idx] <= 1'b0;
                  end else begin
                     k_q     <= k_q + 1'b1;
                     state_q <= WB_REQ;
                  end
               end
            end
            FE_REQ: begin
               mem_read_q    <= 1'b1;
               mem_address_q <= {cpu_tag, idx, k_q};
               if (mem_busy_wait) state_q <= FE_WAIT;
            end
            FE_WAIT: begin
               if (!mem_busy_wait) begin
                  mem_read_q       <= 1'b0;
                  data_q[idx][k_q] <= mem_rdata;
                  if (k_q == LAST_K) begin
                     k_q     <= '0;
                     state_q <= UPDATE;
                  end else begin
                     k_q     <= k_q + 1'b1;
                     state_q <= FE_REQ;
                  end
               end
            end
            UPDATE: begin
               valid_q[idx] <= 1'b1;
               dirty_q[idx] <= 1'b0;
               tag_q[idx]   <= cpu_tag;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the CPU load/store path and `data_mem`. Hits are serviced at core speed. Misses are serviced as a sequence of single-byte transfers over the slow `read`/`write`/`busy_wait` memory port. `cpu_busy_wait` stalls the CPU while a miss is in progress.

## Interface
Parameters:
- `LINES`, 8: number of cache lines; index width is log2(`LINES`) = 3.
- `BLOCK`, 4: bytes per line; offset width is 2.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `cpu_read`  in  1  load request.
- `cpu_write`  in  1  store request.
- `cpu_address`  in  8  byte address. Tag = [7:5], index = [4:2], offset = [1:0].
- `cpu_wdata`  in  8  store data.
- `cpu_rdata`  out  8  load data.
- `cpu_busy_wait`  out  1  CPU stall.
- `mem_read`  out  1  byte read request to `data_mem`.
- `mem_write`  out  1  byte write request to `data_mem`.
- `mem_address`  out  8  memory byte address.
- `mem_wdata`  out  8  memory write data.
- `mem_rdata`  in  8  memory read data.
- `mem_busy_wait`  in  1  memory busy.

## Operation
- Storage:
  - Per line: `valid`, `dirty`, 3-bit `tag`, and 4 data bytes.
  - Reset clears `valid` and `dirty` on every line; data and tag contents are don't-care.
- Request rules:
  - A request is `cpu_read XOR cpu_write`.
  - Both signals high together is a no-op: never a hit, no stall, no state change.
- Hit: `valid[index]` is set and `tag[index] == cpu_address[7:5]`.
- Read hit:
  - `cpu_rdata` = `data[index][offset]`, combinational.
  - `cpu_busy_wait` = 0.
- Write hit:
  - Byte written at posedge.
  - `dirty[index]` set at the same posedge.
  - `cpu_busy_wait` = 0.
- Miss: `cpu_busy_wait` = 1 combinationally in the same cycle, and the FSM leaves IDLE at that posedge.
- FSM states: IDLE, WB_REQ, WB_WAIT, FE_REQ, FE_WAIT, UPDATE.
  - IDLE → WB_REQ on a miss when the victim line is valid and dirty.
  - IDLE → FE_REQ on any other miss.
  - WB_REQ: byte counter `k` starts at 0.
    - Outputs: `mem_write` = 1, `mem_address` = {victim tag, index, k}, `mem_wdata` = victim byte k.
    - Moves to WB_WAIT on the first posedge where `mem_busy_wait` = 1.
  - WB_WAIT: holds the request until `mem_busy_wait` is sampled 0.
    - At that posedge, `mem_write` drops.
    - `k` < 3: `k` increments and the FSM returns to WB_REQ.
    - `k` = 3: `k` resets to 0 and the FSM moves to FE_REQ.
  - FE_REQ / FE_WAIT: same handshake as the write-back states, using `mem_read`.
    - `mem_address` = {cpu tag, index, k}.
    - `mem_rdata` is captured into line byte k at the posedge where busy is sampled 0.
  - UPDATE (one cycle): sets `valid` = 1, `dirty` = 0, `tag` = cpu tag, then returns to IDLE.
  - Back in IDLE the request re-evaluates as a hit and completes normally. A write sets `dirty` at that point.
- `cpu_busy_wait` = 1 in every non-IDLE state.
- Request lines are driven from registers and are deasserted at the same posedge busy is seen low. This guarantees `data_mem` never sees a stale request on the following negedge.
- A CPU request that changes mid-miss is undefined: the CPU holds its request while stalled. No checking is performed.
- Reset mid-operation:
  - FSM → IDLE, `k` = 0.
  - `mem_read` = `mem_write` = 0 after the reset posedge.
  - All lines are invalidated; a partially filled line stays invalid.

## Timing
- Reset values:
  - `mem_read` = 0, `mem_write` = 0, `mem_address` = 0, `mem_wdata` = 0.
  - `cpu_busy_wait` = 0 when no request is present.
  - `cpu_rdata` = 0 when there is no read hit.
- Hit latency: 0 stall cycles.
- Clean-miss penalty: 4 × (memory transfer + 2) + 1 (UPDATE) cycles.
- Dirty-miss penalty: adds 4 × (memory transfer + 2) cycles for the write-back.
- At most one memory request line is high at any time; `mem_read` and `mem_write` are never high together.
- `mem_address` and `mem_wdata` are stable for the entire time the request line is high.

## Test plan
- Reset, then read 0x00 → miss; 4 fetches at 0x00–0x03; `cpu_busy_wait` falls after UPDATE. Preload memory with 0x11..0x14 → `cpu_rdata` = 0x11.
- Read 0x02 immediately after that fill → `cpu_busy_wait` stays 0; `cpu_rdata` = 0x13; no memory request.
- Write 0x2A to 0x01 (hit) → no stall; a subsequent read of 0x01 returns 0x2A; `dirty[0]` = 1.
- Read 0x20 (same index, tag 1) → 4 writes to 0x00–0x03, with 0x2A written at 0x01; then 4 reads from 0x20–0x23; `data_mem[0x01]` = 0x2A.
- `cpu_read` = `cpu_write` = 1 at 0x40 → no stall, no memory activity, no array change.
- Assert `rst` during FE_WAIT of a miss to 0x44 → `mem_read` = 0 after that posedge; FSM in IDLE; a re-issued read of 0x44 misses and refetches all 4 bytes.
